// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: fetch state encoding and widths shared by control, fetch and decode
package instruction_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FDONE, PCDONE} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: cycles spent waiting on instruction memory, saturating at its terminal count
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !tc) count <= count + CW'(1);
  assign tc = count == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and instruction-memory reader driven by control-unit handshakes
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              startInstructionFetch,
  input  logic              programCounterWrite,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              haltExecution,
  output logic              instructionFetched,
  output logic              programCounterUpdated,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pcOut,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [DATA_W-1:0] imemRdata,
  input  logic              imemAck,
  output logic              fetchFault,
  output logic              alignFault
);
  fetch_state_t state, next_state;
  logic accept_pc, accept_fetch, tc, timeout;
  assign accept_pc = state == IDLE && !haltExecution && programCounterWrite;
  assign accept_fetch = state == IDLE && !haltExecution && !programCounterWrite && startInstructionFetch;
  assign timeout = state == REQ && !imemAck && tc;
  fetch_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .clear(accept_fetch),
    .enable(state == REQ),
    .tc(tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept_pc ? PCDONE : accept_fetch ? REQ : IDLE;
      REQ:     next_state = imemAck ? FDONE : tc ? IDLE : REQ;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    imemReq = state == REQ;
    instructionFetched = state == FDONE;
    programCounterUpdated = state == PCDONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcOut <= RESET_PC;
      imemAddr <= RESET_PC;
      instruction <= '0;
      fetchFault <= 1'b0;
      alignFault <= 1'b0;
    end else begin
      if (accept_pc) pcOut <= branchTaken ? {branchTarget[ADDR_W-1:2], 2'b00} : pcOut + ADDR_W'(INSTR_BYTES);
      if (accept_pc && branchTaken && branchTarget[1:0] != 2'b00) alignFault <= 1'b1;
      if (accept_fetch) imemAddr <= pcOut;
      if (state == REQ && imemAck) instruction <= imemRdata;
      if (timeout) fetchFault <= 1'b1;
    end
endmodule
